// File: rtl/bscan_spi_multi_if.sv
// JTAG user-register and SPI signal bundle for bscan_spi_multi.
// The slave modport is the bridge; the master modport is the TAP/board side driving it.
interface bscan_spi_multi_if #(
  parameter int NUM_CS = 2
);
  logic              sel;
  logic              capture;
  logic              shift;
  logic              update;
  logic              tdi;
  logic              tdo;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [NUM_CS-1:0] spi_csn;
  logic              busy;
  logic              sel_err;
  logic              overflow;

  modport master (
    output sel, capture, shift, update, tdi, spi_miso,
    input  tdo, spi_sclk, spi_mosi, spi_csn, busy, sel_err, overflow
  );

  modport slave (
    input  sel, capture, shift, update, tdi, spi_miso,
    output tdo, spi_sclk, spi_mosi, spi_csn, busy, sel_err, overflow
  );
endinterface

// File: rtl/bscan_spi_multi.sv
// JTAG-to-SPI bridge: a {MAGIC, cs_idx, len} header opens one SPI burst of len bits on drck.
// Define BSCAN_SPI_READBACK_EN to capture MISO into a DEPTH-bit buffer read back on tdo.
//
// state | meaning
// HUNT  | shifting header bits, waiting for the sync word
// XFER  | chip select low, counting down len bits
// DONE  | burst finished or rejected; idle until the next scan
module bscan_spi_multi #(
  parameter int          NUM_CS = 2,
  parameter int          LEN_W  = 24,
  parameter int          DEPTH  = 16384,
  parameter logic [31:0] MAGIC  = 32'h59A659A6
) (
  input logic              rst,
  input logic              drck,
  bscan_spi_multi_if.slave bus
);
  localparam int HDR_W = 32 + 4 + LEN_W;

  typedef enum logic [1:0] {HUNT = 2'd0, XFER = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d, hdr_sh;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cs_q, cs_d;
  logic              cs_active_q, cs_active_d;
  logic              sel_err_q, sel_err_d;
  logic              ir;
  logic              hdr_match;
  logic              cs_ok;
  logic [NUM_CS-1:0] csn;

  // Every new DR scan (capture/update/deselect) restarts the bridge.
  assign ir        = rst | bus.capture | bus.update | ~bus.sel;
  assign hdr_sh    = {hdr_q[HDR_W-2:0], bus.tdi};
  assign hdr_match = (hdr_sh[HDR_W-1 -: 32] == MAGIC);
  assign cs_ok     = ({1'b0, hdr_sh[LEN_W +: 4]} < 5'(NUM_CS));

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    sel_err_d = sel_err_q;
    case (state_q)
      HUNT: begin
        if (bus.shift) begin
          hdr_d = hdr_sh;
          if (hdr_match) begin
            cnt_d = hdr_sh[LEN_W-1:0];
            cs_d  = hdr_sh[LEN_W +: 4];
            if (!cs_ok) sel_err_d = 1'b1;
            state_d = (cs_ok && hdr_sh[LEN_W-1:0] != '0) ? XFER : DONE;
          end
        end
      end
      XFER: begin
        if (cs_active_q && cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge drck or posedge ir) begin
    if (ir) begin
      state_q <= HUNT;
      hdr_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
    end
  end

  always_ff @(posedge drck or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  // Chip select moves only while drck is low so the gated sclk never glitches.
  assign cs_active_d = (state_q == XFER);

  always_ff @(negedge drck or posedge ir) begin
    if (ir) cs_active_q <= 1'b0;
    else    cs_active_q <= cs_active_d;
  end

  always_comb begin
    csn = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_active_q && cs_q == 4'(i)) csn[i] = 1'b0;
    end
  end

  assign bus.spi_csn  = csn;
  assign bus.spi_sclk = drck & cs_active_q;
  assign bus.spi_mosi = bus.tdi;
  assign bus.busy     = cs_active_q;
  assign bus.sel_err  = sel_err_q;

`ifdef BSCAN_SPI_READBACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] buf_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             full_q;
  logic             ovf_q;

  always_ff @(posedge drck or posedge ir) begin
    if (ir) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(1);
      if (cs_active_q && !full_q) begin
        if (wr_ptr_q == AW'(DEPTH-1)) full_q <= 1'b1;
        else                          wr_ptr_q <= wr_ptr_q + AW'(1);
      end
    end
  end

  // Buffer contents must survive the capture that starts the readback scan.
  always_ff @(posedge drck) begin
    if (cs_active_q && !full_q) buf_q[wr_ptr_q] <= bus.spi_miso;
  end

  always_ff @(posedge drck or posedge rst) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (cs_active_q && full_q) ovf_q <= 1'b1;
  end

  assign bus.tdo      = buf_q[rd_ptr_q];
  assign bus.overflow = ovf_q;
`else
  assign bus.tdo      = bus.spi_miso;
  assign bus.overflow = 1'b0;
`endif
endmodule
